// File: rtl/neuron_layer_sequencer.sv
// -----------------------------------------------------------------------------
// neuron_layer_sequencer
//
// Shares one external neuron datapath (multiply / sum / threshold) across
// NUM_NEURONS neuron contexts. Each context holds 33 weight words and a
// 32-bit enable mask in an internal register file. A start pulse latches a
// 32-word input vector. Each neuron is then evaluated in index order, and
// every axon result is streamed out over a valid/ready handshake.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start               begin a layer pass (sampled only while idle)
//   in_dendrites        input vector, latched when start is accepted
//   cfg_we/neuron/word/data  config write port (word 0..32 weight, 33 mask)
//   cfg_ready           config writes accepted (not busy)
//   dp_dendrites/weights/enabled  operands to the shared datapath
//   dp_axon             combinational datapath result
//   busy                pass in progress
//   res_valid/ready/index/axon    result stream
//   done                one-cycle pulse after the last result is accepted
// -----------------------------------------------------------------------------
module neuron_layer_sequencer #(
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [31:0][31:0]      in_dendrites,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_neuron,
  input  logic [5:0]             cfg_word,
  input  logic [31:0]            cfg_data,
  output logic                   cfg_ready,
  output logic [31:0][31:0]      dp_dendrites,
  output logic [32:0][31:0]      dp_weights,
  output logic [31:0]            dp_enabled,
  input  logic [31:0]            dp_axon,
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [IDX_W-1:0]       res_index,
  output logic [31:0]            res_axon,
  output logic                   done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_t                  state_r;
  logic [IDX_W-1:0]        idx_r;
  logic [31:0][31:0]       dend_r;
  logic                    busy_r;
  logic                    res_valid_r;
  logic [IDX_W-1:0]        res_index_r;
  logic [31:0]             res_axon_r;
  logic                    done_r;

  logic [32:0][31:0]       weights_r [NUM_NEURONS];
  logic [31:0]             masks_r   [NUM_NEURONS];

  // Context register file; writes land only while idle and on legal addresses.
  // Matching each legal neuron index explicitly drops out-of-range targets.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        weights_r[n] <= '0;
        masks_r[n]   <= '0;
      end
    end else if (cfg_we && !busy_r) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        if (cfg_neuron == IDX_W'(n)) begin
          if (cfg_word == 6'd33) begin
            masks_r[n] <= cfg_data;
          end else if (cfg_word < 6'd33) begin
            weights_r[n][cfg_word] <= cfg_data;
          end
        end
      end
    end
  end

  // Sequencer FSM: latch, evaluate one neuron, hold the result until accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      idx_r       <= '0;
      dend_r      <= '0;
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
      res_index_r <= '0;
      res_axon_r  <= 32'd0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            dend_r  <= in_dendrites;
            idx_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= S_EVAL;
          end
        end
        S_EVAL: begin
          res_axon_r  <= dp_axon;
          res_index_r <= idx_r;
          res_valid_r <= 1'b1;
          state_r     <= S_EMIT;
        end
        S_EMIT: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            if (idx_r == LAST_IDX) begin
              done_r  <= 1'b1;
              state_r <= S_DONE;
            end else begin
              idx_r   <= idx_r + IDX_W'(1);
              state_r <= S_EVAL;
            end
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r     <= S_IDLE;
          busy_r      <= 1'b0;
          res_valid_r <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  // Datapath operands are presented only in the evaluation cycle. They are read
  // straight from the register file, so a write committed on the start edge
  // is already visible here.
  always_comb begin
    dp_dendrites = '0;
    dp_weights   = '0;
    dp_enabled   = 32'd0;
    if (state_r == S_EVAL) begin
      dp_dendrites = dend_r;
      dp_weights   = weights_r[idx_r];
      dp_enabled   = masks_r[idx_r];
    end else begin
      dp_dendrites = '0;
      dp_weights   = '0;
      dp_enabled   = 32'd0;
    end
  end

  assign busy      = busy_r;
  assign cfg_ready = ~busy_r;
  assign res_valid = res_valid_r;
  assign res_index = res_index_r;
  assign res_axon  = res_axon_r;
  assign done      = done_r;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_neuron_layer_sequencer
//
// Self-checking bench for neuron_layer_sequencer. A simple datapath stub
// computes the axon as the bias word plus the sum of enabled dendrite*weight
// products. The expected axons come from a model of the context store that
// the bench keeps itself. Inputs are driven and outputs are sampled just after
// the falling edge.
// -----------------------------------------------------------------------------
module tb_neuron_layer_sequencer;

  localparam int N  = 8;
  localparam int IW = $clog2(N);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [31:0][31:0]    in_dendrites;
  logic                 cfg_we;
  logic [IW-1:0]        cfg_neuron;
  logic [5:0]           cfg_word;
  logic [31:0]          cfg_data;
  logic                 cfg_ready;
  logic [31:0][31:0]    dp_dendrites;
  logic [32:0][31:0]    dp_weights;
  logic [31:0]          dp_enabled;
  logic [31:0]          dp_axon;
  logic                 busy;
  logic                 res_valid;
  logic                 res_ready;
  logic [IW-1:0]        res_index;
  logic [31:0]          res_axon;
  logic                 done;

  neuron_layer_sequencer #(.NUM_NEURONS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_dendrites(in_dendrites),
    .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_word(cfg_word),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .dp_dendrites(dp_dendrites),
    .dp_weights(dp_weights), .dp_enabled(dp_enabled), .dp_axon(dp_axon),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_index(res_index), .res_axon(res_axon), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stub: bias plus enabled products.
  always_comb begin
    dp_axon = dp_weights[32];
    for (int k = 0; k < 32; k++) begin
      if (dp_enabled[k]) dp_axon = dp_axon + dp_dendrites[k] * dp_weights[k];
    end
  end

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_w    [N][33];
  logic [31:0] m_mask [N];

  typedef struct {
    int          n;
    int          word;
    logic [31:0] data;
    bit          applied;
  } cfg_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int n = 0; n < N; n++) begin
      m_mask[n] = 32'd0;
      for (int k = 0; k < 33; k++) m_w[n][k] = 32'd0;
    end
  endfunction

  function automatic logic [31:0] model_axon(input int n, input logic [31:0][31:0] d);
    logic [31:0] acc;
    acc = m_w[n][32];
    for (int k = 0; k < 32; k++) begin
      if (m_mask[n][k]) acc = acc + d[k] * m_w[n][k];
    end
    return acc;
  endfunction

  // One config write in an idle cycle; the model follows only if told the write lands.
  task automatic cfg_write(input int n, input int w, input logic [31:0] d, input bit apply);
    cfg_we = 1'b1; cfg_neuron = IW'(n); cfg_word = 6'(w); cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (apply) begin
      if (w < 33) m_w[n][w] = d;
      else m_mask[n] = d;
    end
  endtask

  // One layer pass. fix_idx/fix_len force a stall on one neuron. abort_at resets mid-EMIT.
  task automatic run_pass(input logic [31:0][31:0] dv, input int stall_max,
                          input int fix_idx, input int fix_len, input bit pokes,
                          input int abort_at, input bit sw, input logic [31:0] sw_data,
                          input bit start_in_done);
    logic [31:0] exp;
    int t0, stall, total;
    total = 0;
    chk("idle_cfg_ready", cfg_ready, 1);
    start = 1'b1; in_dendrites = dv;
    if (sw) begin
      cfg_we = 1'b1; cfg_neuron = '0; cfg_word = 6'd33; cfg_data = sw_data;
      m_mask[0] = sw_data;
    end
    t0 = cyc;
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    for (int k = 0; k < 32; k++) in_dendrites[k] = $urandom();
    for (int n = 0; n < N; n++) begin
      exp = model_axon(n, dv);
      chk("eval_busy", busy, 1);
      chk("eval_valid", res_valid, 0);
      chk("eval_dend", dp_dendrites == dv, 1);
      chk("eval_mask", dp_enabled, m_mask[n]);
      chk("eval_bias", dp_weights[32], m_w[n][32]);
      @(negedge clk);
      stall = (n == fix_idx) ? fix_len : ((stall_max > 0) ? $urandom_range(stall_max, 0) : 0);
      total += stall;
      for (int s = 0; s <= stall; s++) begin
        chk("emit_valid", res_valid, 1);
        chk("emit_index", res_index, n);
        chk("emit_axon", res_axon, exp);
        chk("emit_dp_zero", (dp_enabled == 32'd0) && (dp_weights == '0) && (dp_dendrites == '0), 1);
        chk("emit_cfg_ready", cfg_ready, 0);
        if (n == abort_at) begin
          rst_n = 1'b0; res_ready = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          chk("abort_busy", busy, 0);
          chk("abort_valid", res_valid, 0);
          chk("abort_done", done, 0);
          model_clear();
          @(negedge clk);
          chk("abort_no_done", done, 0);
          chk("abort_idle", busy, 0);
          return;
        end
        if (pokes && s < stall) begin
          cfg_we = 1'b1; cfg_neuron = IW'($urandom()); cfg_word = 6'($urandom_range(33, 0));
          cfg_data = $urandom(); start = 1'b1;
        end else begin
          cfg_we = 1'b0; start = 1'b0;
        end
        res_ready = (s == stall);
        @(negedge clk);
      end
      res_ready = 1'b0; cfg_we = 1'b0; start = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("done_cycle", cyc - t0, 2 * N + 1 + total);
    start = start_in_done;
    @(negedge clk);
    start = 1'b0;
    chk("after_done_low", done, 0);
    chk("after_idle", busy, 0);
    chk("after_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    chk("no_second_pass", busy, 0);
  endtask

  logic [31:0][31:0] ones;
  logic [31:0][31:0] rv;
  cfg_vec_t          tbl [8];

  initial begin
    for (int k = 0; k < 32; k++) ones[k] = 32'd1;
    tbl[0] = '{2, 5,  32'h0000_0011, 1'b1};
    tbl[1] = '{2, 33, 32'h0000_F0F0, 1'b1};
    tbl[2] = '{3, 40, 32'h0000_DEAD, 1'b0};
    tbl[3] = '{3, 63, 32'h1234_5678, 1'b0};
    tbl[4] = '{3, 34, 32'h0BAD_F00D, 1'b0};
    tbl[5] = '{5, 32, 32'h0000_0077, 1'b1};
    tbl[6] = '{0, 33, 32'h0000_0001, 1'b1};
    tbl[7] = '{7, 0,  32'h0000_0003, 1'b1};

    rst_n = 1'b0; start = 1'b1; in_dendrites = ones; cfg_we = 1'b0;
    cfg_neuron = '0; cfg_word = 6'd0; cfg_data = 32'd0; res_ready = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_dp_zero", (dp_enabled == 32'd0) && (dp_weights == '0) && (dp_dendrites == '0), 1);
    chk("rst_index", res_index, 0);
    chk("rst_axon", res_axon, 0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", busy, 0);

    // Readback after reset: all contexts zero.
    run_pass(ones, 0, -1, 0, 1'b0, -1, 1'b0, 32'd0, 1'b0);

    // weights[n][k] = n+1, full mask, unit dendrites.
    for (int n = 0; n < N; n++) begin
      for (int k = 0; k < 33; k++) cfg_write(n, k, 32'(n + 1), 1'b1);
      cfg_write(n, 33, 32'hFFFF_FFFF, 1'b1);
    end
    run_pass(ones, 0, -1, 0, 1'b0, -1, 1'b0, 32'd0, 1'b0);

    // Backpressure on index 3 with rejected writes/starts, start asserted in DONE.
    for (int k = 0; k < 32; k++) rv[k] = $urandom_range(255, 0);
    run_pass(rv, 0, 3, 5, 1'b1, -1, 1'b0, 32'd0, 1'b1);

    // Table of config writes, some of which must be dropped.
    for (int i = 0; i < 8; i++) cfg_write(tbl[i].n, tbl[i].word, tbl[i].data, tbl[i].applied);
    run_pass(rv, 0, -1, 0, 1'b0, -1, 1'b0, 32'd0, 1'b0);

    // Same-cycle mask write and start on neuron 0.
    run_pass(rv, 0, -1, 0, 1'b0, -1, 1'b1, 32'h0000_00A5, 1'b0);

    // Randomized passes with random writes and random backpressure.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 12; i++) begin
        int n, w;
        n = $urandom_range(N - 1, 0);
        w = $urandom_range(63, 0);
        cfg_write(n, w, $urandom(), w <= 33);
      end
      for (int k = 0; k < 32; k++) rv[k] = $urandom();
      run_pass(rv, 3, -1, 0, 1'b1, -1, p[0], $urandom(), p[1]);
    end

    // Reset during EMIT of index 5, then all contexts read back as zero.
    run_pass(rv, 0, -1, 0, 1'b0, 5, 1'b0, 32'd0, 1'b0);
    run_pass(rv, 0, -1, 0, 1'b0, -1, 1'b0, 32'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
